// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch / load-store RAM arbiter:
// requester ids, the in-flight response tag and the latency bound.
package mem_arb_pkg;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // Largest RAM read latency the tag pipeline is expected to cover.
   localparam int MAX_RD_LATENCY = 4;

   // One entry per cycle travels down the response pipeline.
   typedef struct packed {
      logic valid;
      logic id;
      logic we;
   } arb_tag_t;

endpackage

// File: rtl/arb_resp_pipe.sv
// Fixed-depth shift register carrying the owner tag of each RAM access
// until its response returns. A low reset_n empties every stage.
import mem_arb_pkg::*;

module arb_resp_pipe #(
   parameter int DEPTH = 1
) (
   input  logic     clk,
   input  logic     reset_n,
   input  arb_tag_t push,
   output arb_tag_t pop
);

   arb_tag_t stage_reg [DEPTH];

   // Shift one stage per cycle; stage 0 takes this cycle's grant tag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= push;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign pop = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one RAM port between instruction fetch
// and load/store. Define MEM_ARB_RR_EN for round-robin arbitration;
// otherwise data requests have fixed priority over fetch requests.
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic              grant_d;
   logic              grant_if;
   logic [ADDR_W-1:0] addr_sel;
   arb_tag_t          push_tag;
   arb_tag_t          pop_tag;

`ifdef MEM_ARB_RR_EN
   logic last_reg;

   // Remember who won the most recent grant so a tie goes the other way.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_reg <= REQ_IF;
      end else if (grant_d || grant_if) begin
         last_reg <= grant_d ? REQ_D : REQ_IF;
      end
   end

   // Round-robin grant: only a tie consults the last-grant register.
   always_comb begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
      if (reset_n) begin
         if (d_req && if_req) begin
            grant_d  = (last_reg == REQ_IF);
            grant_if = (last_reg == REQ_D);
         end else begin
            grant_d  = d_req;
            grant_if = if_req;
         end
      end
   end
`else
   // Fixed priority grant: a data request always beats a fetch request.
   always_comb begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
      if (reset_n) begin
         grant_d  = d_req;
         grant_if = if_req && !d_req;
      end
   end
`endif

   assign d_gnt  = grant_d;
   assign if_gnt = grant_if;

   // Steer the granted request onto the RAM port; fetches never write.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = '0;
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
      if (grant_d) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         addr_sel  = d_addr;
         mem_wdata = d_wdata;
         mem_wstrb = d_we ? d_wstrb : 4'b0000;
      end else if (grant_if) begin
         mem_en    = 1'b1;
         addr_sel  = if_addr;
      end
   end

   // The RAM is word addressed in practice, so drop the byte offset.
   assign mem_addr = addr_sel & {{(ADDR_W-2){1'b1}}, 2'b00};

   assign push_tag.valid = grant_d || grant_if;
   assign push_tag.id    = grant_d ? REQ_D : REQ_IF;
   assign push_tag.we    = grant_d && d_we;

   arb_resp_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_resp_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_tag),
      .pop     (pop_tag)
   );

   // Route the returning response to its owner; gate with reset so a
   // tag still sitting in the last stage cannot escape during reset.
   always_comb begin
      if_rvalid = reset_n && pop_tag.valid && (pop_tag.id == REQ_IF);
      d_rvalid  = reset_n && pop_tag.valid && (pop_tag.id == REQ_D);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = (d_rvalid && !pop_tag.we) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with read latencies
// 1, 2 and 3 share one clock and reset; a cycle table drives them.
module tb_mem_arbiter;

   typedef struct packed {
      logic        ig;
      logic        dg;
      logic        men;
      logic        mwe;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic [3:0]  mws;
      logic        irv;
      logic [31:0] ird;
      logic        drv;
      logic [31:0] drd;
   } out_t;

   typedef struct packed {
      logic [1:0]  inst;
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [3:0]  dws;
      logic [31:0] mrd;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req    [3];
   logic [31:0] if_addr   [3];
   logic        if_gnt    [3];
   logic        if_rvalid [3];
   logic [31:0] if_rdata  [3];
   logic        d_req     [3];
   logic        d_we      [3];
   logic [31:0] d_addr    [3];
   logic [31:0] d_wdata   [3];
   logic [3:0]  d_wstrb   [3];
   logic        d_gnt     [3];
   logic        d_rvalid  [3];
   logic [31:0] d_rdata   [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [31:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];
   logic [3:0]  mem_wstrb [3];
   logic [31:0] mem_rdata [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mem_arbiter #(
         .ADDR_W     (32),
         .DATA_W     (32),
         .RD_LATENCY (gi + 1)
      ) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .if_req    (if_req[gi]),
         .if_addr   (if_addr[gi]),
         .if_gnt    (if_gnt[gi]),
         .if_rvalid (if_rvalid[gi]),
         .if_rdata  (if_rdata[gi]),
         .d_req     (d_req[gi]),
         .d_we      (d_we[gi]),
         .d_addr    (d_addr[gi]),
         .d_wdata   (d_wdata[gi]),
         .d_wstrb   (d_wstrb[gi]),
         .d_gnt     (d_gnt[gi]),
         .d_rvalid  (d_rvalid[gi]),
         .d_rdata   (d_rdata[gi]),
         .mem_en    (mem_en[gi]),
         .mem_we    (mem_we[gi]),
         .mem_addr  (mem_addr[gi]),
         .mem_wdata (mem_wdata[gi]),
         .mem_wstrb (mem_wstrb[gi]),
         .mem_rdata (mem_rdata[gi])
      );
   end

   function automatic vec_t mk(input int inst, input bit ir, input logic [31:0] ia,
                               input bit dr, input bit dwe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dws,
                               input logic [31:0] mrd,
                               input bit ig, input bit dg, input bit men, input bit mwe,
                               input logic [31:0] maddr, input logic [31:0] mwd,
                               input logic [3:0] mws, input bit irv, input logic [31:0] ird,
                               input bit drv, input logic [31:0] drd);
      vec_t v;
      v.inst = inst[1:0];
      v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
      v.dwd = dwd; v.dws = dws; v.mrd = mrd;
      v.exp.ig = ig; v.exp.dg = dg; v.exp.men = men; v.exp.mwe = mwe;
      v.exp.maddr = maddr; v.exp.mwd = mwd; v.exp.mws = mws;
      v.exp.irv = irv; v.exp.ird = ird; v.exp.drv = drv; v.exp.drd = drd;
      return v;
   endfunction

   function automatic out_t act(input int k);
      return {if_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k],
              mem_wstrb[k], if_rvalid[k], if_rdata[k], d_rvalid[k], d_rdata[k]};
   endfunction

   task automatic idle_all();
      for (int k = 0; k < 3; k++) begin
         if_req[k] = 1'b0; if_addr[k] = '0;
         d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0;
         d_wdata[k] = '0; d_wstrb[k] = '0; mem_rdata[k] = '0;
      end
   endtask

   task automatic chk_out(input string nm, input out_t a, input out_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic chk_bit(input string nm, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, a, e);
      end
   endtask

   vec_t vq[$];

   initial begin
      // Cycle table: inst, ir, ia, dr, dwe, da, dwd, dws, mrd |
      //              ig, dg, men, mwe, maddr, mwd, mws, irv, ird, drv, drd
      // Fetch stream, latency 2
      vq.push_back(mk(1, 1, 32'h00, 0, 0, 0, 0, 0, 0,            1, 0, 1, 0, 32'h00, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(1, 1, 32'h04, 0, 0, 0, 0, 0, 0,            1, 0, 1, 0, 32'h04, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(1, 1, 32'h08, 0, 0, 0, 0, 0, 32'h11,       1, 0, 1, 0, 32'h08, 0, 0, 1, 32'h11, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h22,            0, 0, 0, 0, 0, 0, 0, 1, 32'h22, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h33,            0, 0, 0, 0, 0, 0, 0, 1, 32'h33, 0, 0));
      // Store ack, latency 2, unaligned address
      vq.push_back(mk(1, 0, 0, 1, 1, 32'h103, 32'hDEADBEEF, 4'b0001, 32'h77777777,
                      0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'b0001, 0, 0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h12345678,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D,      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      // Mixed routing, latency 1
      vq.push_back(mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0,            1, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 32'h80, 0, 0, 32'hAAAA0000, 0, 1, 1, 0, 32'h80, 0, 0, 1, 32'hAAAA0000, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h5555FFFF,      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555FFFF));
      // Back-to-back with request and response in the same cycle
      vq.push_back(mk(0, 0, 0, 1, 0, 32'h84, 0, 0, 0,            0, 1, 1, 0, 32'h84, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h46, 0, 0, 0, 0, 0, 32'h01010101, 1, 0, 1, 0, 32'h44, 0, 0, 0, 0, 1, 32'h01010101));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h02020202,      0, 0, 0, 0, 0, 0, 0, 1, 32'h02020202, 0, 0));
      // Contention: both requesters held for 4 cycles, latency 1
`ifdef MEM_ARB_RR_EN
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 0,       0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 32'hA1,  1, 0, 1, 0, 32'h10, 0, 0, 0, 0, 1, 32'hA1));
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 32'hA2,  0, 1, 1, 0, 32'h20, 0, 0, 1, 32'hA2, 0, 0));
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 32'hA3,  1, 0, 1, 0, 32'h10, 0, 0, 0, 0, 1, 32'hA3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hA4,            0, 0, 0, 0, 0, 0, 0, 1, 32'hA4, 0, 0));
`else
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 0,       0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 32'hA1,  0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 1, 32'hA1));
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 32'hA2,  0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 1, 32'hA2));
      vq.push_back(mk(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 32'hA3,  0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 1, 32'hA3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hA4,            0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA4));
`endif

      // Reset with both requests asserted on every instance
      idle_all();
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if_req[k] = 1'b1; if_addr[k] = 32'h10;
         d_req[k] = 1'b1; d_addr[k] = 32'h20;
         mem_rdata[k] = 32'hFFFFFFFF;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk_out($sformatf("reset_outputs_l%0d", k + 1), act(k), '0);
         $display("reset inst %0d outputs %h", k, act(k));
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk_bit($sformatf("first_dgnt_l%0d", k + 1), d_gnt[k], 1'b1);
         chk_bit($sformatf("first_ifgnt_l%0d", k + 1), if_gnt[k], 1'b0);
         $display("release inst %0d d_gnt=%b if_gnt=%b", k, d_gnt[k], if_gnt[k]);
      end
      @(posedge clk); #1;
      idle_all();
      repeat (4) @(posedge clk);

      // Cycle table
      for (int r = 0; r < vq.size(); r++) begin
         int k;
         k = int'(vq[r].inst);
         #1;
         idle_all();
         if_req[k] = vq[r].ir; if_addr[k] = vq[r].ia;
         d_req[k] = vq[r].dr; d_we[k] = vq[r].dwe; d_addr[k] = vq[r].da;
         d_wdata[k] = vq[r].dwd; d_wstrb[k] = vq[r].dws; mem_rdata[k] = vq[r].mrd;
         @(negedge clk);
         chk_out($sformatf("row%0d_l%0d", r, k + 1), act(k), vq[r].exp);
         $display("row %0d inst %0d outputs %h", r, k, act(k));
         @(posedge clk);
      end

      // Reset while loads are in flight on latency 1 and 3
      #1;
      idle_all();
      for (int k = 0; k < 3; k += 2) begin
         d_req[k] = 1'b1; d_addr[k] = 32'h200;
      end
      @(negedge clk);
      chk_bit("midflight_gnt_l1", d_gnt[0], 1'b1);
      chk_bit("midflight_gnt_l3", d_gnt[2], 1'b1);
      $display("midflight grant d_gnt l1=%b l3=%b", d_gnt[0], d_gnt[2]);
      @(posedge clk); #1;
      idle_all();
      for (int k = 0; k < 3; k++) mem_rdata[k] = 32'hFFFFFFFF;
      reset_n = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk_bit($sformatf("midflight_rvalid_l1_t%0d", c), d_rvalid[0], 1'b0);
         chk_bit($sformatf("midflight_rvalid_l3_t%0d", c), d_rvalid[2], 1'b0);
         $display("midflight T+%0d d_rvalid l1=%b l3=%b", c, d_rvalid[0], d_rvalid[2]);
         @(posedge clk); #1;
         reset_n = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
